// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the fetch PC, addresses imem and
// buffers {pc, instr} in a prefetch FIFO that feeds decode.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] FULL =
    CW'(FIFO_DEPTH);

  localparam logic [31:0] RESET_PC =
    {RESET_VECTOR[31:2], 2'b00};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  fetch_t fifo_q [FIFO_DEPTH];

  logic [31:0]   fetch_pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic   pop;
  logic   push;
  fetch_t head;

  // Target byte-offset bits are meaningless for word fetch.
  logic unused_tgt;
  assign unused_tgt = ^redirect_target[1:0];

  assign imem_addr = {2'b00, fetch_pc[31:2]};

  assign if_valid = (count != '0);
  assign head     = fifo_q[rd_ptr];
  assign if_pc    = if_valid ? head.pc    : '0;
  assign if_instr = if_valid ? head.instr : '0;

  // A full FIFO can still accept a fetch when its head leaves.
  assign pop  = if_valid & if_ready;
  assign push = ~halt & ~redirect_valid &
                ((count != FULL) | pop);

  // PC, pointers and occupancy; redirect flushes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_target[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= '{pc: fetch_pc,
                          instr: imem_data};
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized stimulus, queue model
// of fetched instructions and a decoupled pop monitor.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam int          DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        halt;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] mpc;
  int          checks;
  int          failures;

  instruction_fetch_unit #(
    .RESET_VECTOR (RV),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .halt            (halt),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc)
  );

  // Memory: word k holds 0x1000_0000 + k.
  assign imem_data = 32'h1000_0000 + imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return 32'h1000_0000 + {2'b00, pc[31:2]};
  endfunction

  // Monitor: every accepted head must match the oldest expected.
  always @(negedge clk) begin
    if (reset && if_valid && if_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected actual_pc=%h expected=none",
                 if_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_pc", if_pc, e.pc);
        check("pop_instr", if_instr, e.instr);
      end
    end
  end

  // One cycle: check state, drive inputs, advance the model.
  task automatic step(input logic h, input logic r,
                      input logic rv, input logic [31:0] tgt);
    bit mpop;
    bit mpush;
    check("if_valid", {31'b0, if_valid},
          {31'b0, exp_q.size() != 0});
    check("imem_addr", imem_addr, {2'b00, mpc[31:2]});
    if (exp_q.size() == 0) begin
      check("if_pc_gated", if_pc, 32'h0);
      check("if_instr_gated", if_instr, 32'h0);
    end
    halt            = h;
    if_ready        = r;
    redirect_valid  = rv;
    redirect_target = tgt;
    mpop  = (exp_q.size() != 0) && r;
    mpush = !h && !rv && ((exp_q.size() < DEPTH) || mpop);
    if (rv) begin
      exp_q.delete();
      mpc = {tgt[31:2], 2'b00};
    end else if (mpush) begin
      exp_q.push_back('{pc: mpc, instr: word_of(mpc)});
      mpc = mpc + 32'd4;
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b0;
    halt            = 1'b0;
    if_ready        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    mpc             = {RV[31:2], 2'b00};

    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", {31'b0, if_valid}, 32'h0);
    check("rst_addr", imem_addr, {2'b00, mpc[31:2]});
    check("rst_pc", if_pc, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    reset = 1'b1;

    // Streaming from the reset vector.
    repeat (6) step(0, 1, 0, 0);

    // Backpressure from a clean start at 0.
    step(0, 1, 1, 32'h0);
    repeat (5) step(0, 0, 0, 0);
    check("bp_addr_stall", imem_addr, 32'h2);
    check("bp_head_pc", if_pc, 32'h0);
    repeat (6) step(0, 1, 0, 0);

    // Redirect while pc 8 is at the head.
    step(0, 1, 1, 32'h0);
    repeat (3) step(0, 1, 0, 0);
    check("rd_head_pc", if_pc, 32'h8);
    step(0, 1, 1, 32'h0000_0043);
    step(0, 1, 0, 0);
    check("rd_next_pc", if_pc, 32'h40);
    repeat (3) step(0, 1, 0, 0);

    // Halt with two entries queued.
    repeat (2) step(0, 0, 0, 0);
    repeat (4) step(1, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0);

    // PC wrap.
    step(0, 1, 1, 32'hFFFF_FFF8);
    repeat (5) step(0, 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 1) == 1) ? $urandom
            : 32'hFFFF_FFF0 + $urandom_range(0, 15);
      step($urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 11) == 0,
           tgt);
    end

    // Asynchronous reset while full.
    repeat (3) step(0, 0, 0, 0);
    check("pre_rst_full", {31'b0, if_valid}, 32'h1);
    #1;
    reset          = 1'b0;
    halt           = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    exp_q.delete();
    mpc = {RV[31:2], 2'b00};
    #1;
    check("async_valid", {31'b0, if_valid}, 32'h0);
    check("async_addr", imem_addr, {2'b00, mpc[31:2]});
    check("async_pc", if_pc, 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (6) step(0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
